// File: rtl/mem_pkg.sv
// Shared data-memory definitions: arbiter states and addressing-control encodings.
package mem_pkg;

  localparam int unsigned CTRL_BITS = 3;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic [CTRL_BITS-1:0] CTRL_B  = 3'b000;
  localparam logic [CTRL_BITS-1:0] CTRL_H  = 3'b001;
  localparam logic [CTRL_BITS-1:0] CTRL_W  = 3'b010;
  localparam logic [CTRL_BITS-1:0] CTRL_BU = 3'b100;
  localparam logic [CTRL_BITS-1:0] CTRL_HU = 3'b101;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU (port 0) priority, DMA (port 1) starvation guard
// and bounded burst lock. One access per cycle, registered load data.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_LOCK     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [XLEN-1:0]      addr0,
  input  logic [XLEN-1:0]      addr1,
  input  logic [XLEN-1:0]      wdata0,
  input  logic [XLEN-1:0]      wdata1,
  input  logic [CTRL_BITS-1:0] ctrl0,
  input  logic [CTRL_BITS-1:0] ctrl1,
  input  logic                 lock1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [XLEN-1:0]      rdata0,
  output logic [XLEN-1:0]      rdata1,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wd,
  output logic [CTRL_BITS-1:0] mem_ctrl,
  input  logic [XLEN-1:0]      mem_rd
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BEAT_W = $clog2(MAX_LOCK + 1);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  // Grant decision, next state, counters and memory-port mux.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_d  = state_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    mem_we   = 1'b0;
    mem_addr = addr0;
    mem_wd   = wdata0;
    mem_ctrl = ctrl0;

    if (!rst) begin
      case (state_q)
        ARB: begin
          if (req1 && (wait_q == WAIT_W'(STARVE_LIMIT))) begin
            gnt1 = 1'b1;
          end else if (req0) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
          if (gnt1 && lock1) begin
            state_d = LOCKED;
            beat_d  = BEAT_W'(1);
          end
        end
        LOCKED: begin
          if (req1 && lock1 && (beat_q < BEAT_W'(MAX_LOCK))) begin
            gnt1   = 1'b1;
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            // Exit burst: give the cycle to the CPU, DMA must re-win in ARB.
            gnt0    = req0;
            state_d = ARB;
            beat_d  = '0;
          end
        end
        default: begin
          state_d = ARB;
          beat_d  = '0;
        end
      endcase
    end

    if (gnt1 || !req1) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(STARVE_LIMIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_wd   = wdata1;
      mem_ctrl = ctrl1;
    end else begin
      mem_we   = we0 & gnt0;
    end
  end

  // FSM, counters and load-response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      wait_q  <= '0;
      beat_q  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_rd;
      if (gnt1 && !we1) rdata1 <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural byte-addressed memory.
module tb_dmem_arbiter;
  import mem_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STARVE = 8;
  localparam int unsigned MAXL   = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        lock;
  } tx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [XLEN-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [2:0] ctrl0 = '0, ctrl1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [XLEN-1:0] rdata0, rdata1, mem_addr, mem_wd, mem_rd;
  logic [2:0] mem_ctrl;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_ctrl(mem_ctrl),
    .mem_rd(mem_rd)
  );

  function automatic logic [31:0] fmt_load(logic [31:0] w, logic [1:0] off, logic [2:0] c);
    logic [31:0] s;
    s = w >> (8 * off);
    case (c)
      CTRL_B:  return {{24{s[7]}}, s[7:0]};
      CTRL_BU: return {24'h0, s[7:0]};
      CTRL_H:  return {{16{s[15]}}, s[15:0]};
      CTRL_HU: return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [1:0] off, logic [2:0] c);
    logic [31:0] m;
    case (c)
      CTRL_B, CTRL_BU: m = 32'h0000_00FF << (8 * off);
      CTRL_H, CTRL_HU: m = 32'h0000_FFFF << (8 * off);
      default:         m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | ((wd << (8 * off)) & m);
  endfunction

  // Environment memory (driven by mem_*) and the bench's independent shadow.
  logic [31:0] mem_w  [0:63];
  logic [31:0] shadow [0:63];
  assign mem_rd = fmt_load(mem_w[mem_addr[7:2]], mem_addr[1:0], mem_ctrl);

  tx_t q0[$], q1[$];
  logic [31:0] eq0[$], eq1[$];
  logic [1:0] hist[$];
  logic m_locked = 1'b0, exp_rv0 = 1'b0, exp_rv1 = 1'b0;
  int m_wait = 0, m_beat = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_locked = 1'b0; m_wait = 0; m_beat = 0;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    eq0.delete(); eq1.delete(); q0.delete(); q1.delete();
  endtask

  // One clock: drive queue heads, check at negedge, update model and memories.
  task automatic cycle();
    tx_t t0, t1;
    logic g0, g1;
    @(posedge clk); #1;
    t0 = '{default: '0};
    t1 = '{default: '0};
    if (q0.size() > 0) t0 = q0[0];
    if (q1.size() > 0) t1 = q1[0];
    req0 = (q0.size() > 0); we0 = t0.we; addr0 = t0.addr; wdata0 = t0.wdata; ctrl0 = t0.ctrl;
    req1 = (q1.size() > 0); we1 = t1.we; addr1 = t1.addr; wdata1 = t1.wdata; ctrl1 = t1.ctrl;
    lock1 = req1 & t1.lock;
    @(negedge clk);
    g0 = 1'b0; g1 = 1'b0;
    if (!rst) begin
      if (m_locked) begin
        if (req1 && lock1 && m_beat < int'(MAXL)) g1 = 1'b1; else g0 = req0;
      end else begin
        if (req1 && m_wait == int'(STARVE)) g1 = 1'b1;
        else if (req0) g0 = 1'b1;
        else if (req1) g1 = 1'b1;
      end
    end
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("mem_we", mem_we, g1 ? t1.we : (g0 & t0.we));
    if (g1) chk("mem_addr1", mem_addr, t1.addr);
    else if (g0) chk("mem_addr0", mem_addr, t0.addr);
    chk("rvalid0", rvalid0, exp_rv0);
    chk("rvalid1", rvalid1, exp_rv1);
    if (exp_rv0 && eq0.size() > 0) chk("rdata0", rdata0, eq0.pop_front());
    if (exp_rv1 && eq1.size() > 0) chk("rdata1", rdata1, eq1.pop_front());
    hist.push_back({gnt1, gnt0});
    exp_rv0 = g0 & ~t0.we;
    exp_rv1 = g1 & ~t1.we;
    if (g0) begin
      if (t0.we) shadow[t0.addr[7:2]] = merge(shadow[t0.addr[7:2]], t0.wdata, t0.addr[1:0], t0.ctrl);
      else eq0.push_back(fmt_load(shadow[t0.addr[7:2]], t0.addr[1:0], t0.ctrl));
      void'(q0.pop_front());
    end
    if (g1) begin
      if (t1.we) shadow[t1.addr[7:2]] = merge(shadow[t1.addr[7:2]], t1.wdata, t1.addr[1:0], t1.ctrl);
      else eq1.push_back(fmt_load(shadow[t1.addr[7:2]], t1.addr[1:0], t1.ctrl));
      void'(q1.pop_front());
    end
    if (!rst) begin
      if (m_locked) begin
        if (g1) m_beat++;
        else begin m_locked = 1'b0; m_beat = 0; end
      end else if (g1 && lock1) begin
        m_locked = 1'b1; m_beat = 1;
      end
      if (!req1 || g1) m_wait = 0;
      else if (m_wait < int'(STARVE)) m_wait++;
    end
    // Memory write lands here; no load can be granted in a store's cycle.
    if (mem_we) mem_w[mem_addr[7:2]] = merge(mem_w[mem_addr[7:2]], mem_wd, mem_addr[1:0], mem_ctrl);
  endtask

  function automatic tx_t mk(logic we, logic [31:0] a, logic [31:0] d, logic [2:0] c, logic lk);
    tx_t t;
    t.we = we; t.addr = a; t.wdata = d; t.ctrl = c; t.lock = lk;
    return t;
  endfunction

  function automatic tx_t rand_tx(logic is_dma);
    logic [2:0] cs [5];
    logic [2:0] c;
    logic w;
    logic [31:0] a;
    cs = '{CTRL_B, CTRL_H, CTRL_W, CTRL_BU, CTRL_HU};
    c = cs[$urandom_range(0, 4)];
    w = ($urandom_range(0, 1) == 1) && (c == CTRL_B || c == CTRL_H || c == CTRL_W);
    a = 32'($urandom_range(0, 255));
    if (c == CTRL_H || c == CTRL_HU) a[0] = 1'b0;
    if (c == CTRL_W) a[1:0] = 2'b00;
    return mk(w, a, $urandom, c, is_dma && ($urandom_range(0, 1) == 1));
  endfunction

  task automatic drain();
    for (int k = 0; k < 200 && (q0.size() > 0 || q1.size() > 0); k++) cycle();
    cycle();
    cycle();
    chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_w[i]  = 32'h0101_0101 * 32'(i) ^ 32'h5A5A_0000;
      shadow[i] = 32'h0101_0101 * 32'(i) ^ 32'h5A5A_0000;
    end
    mem_w[4]  = 32'hDEAD_BEEF;
    shadow[4] = 32'hDEAD_BEEF;

    // Reset state.
    do_reset();
    cycle();
    cycle();
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    rst = 1'b0;
    cycle();
    cycle();

    // CPU LW from 0x10.
    q0.push_back(mk(1'b0, 32'h10, 32'h0, CTRL_W, 1'b0));
    cycle();
    cycle();
    chk("lw_rdata0", rdata0, 32'hDEAD_BEEF);

    // SB then LBU/LB of the same byte.
    q0.push_back(mk(1'b1, 32'h31, 32'h0000_00AB, CTRL_B, 1'b0));
    q0.push_back(mk(1'b0, 32'h31, 32'h0, CTRL_BU, 1'b0));
    q0.push_back(mk(1'b0, 32'h31, 32'h0, CTRL_B, 1'b0));
    cycle();
    cycle();
    cycle();
    chk("lbu_rdata0", rdata0, 32'h0000_00AB);
    cycle();
    chk("lb_rdata0", rdata0, 32'hFFFF_FFAB);
    drain();

    // Starvation guard with both ports requesting continuously.
    for (int i = 0; i < 20; i++) q0.push_back(mk(1'b0, 32'(4 * i), 32'h0, CTRL_W, 1'b0));
    for (int i = 0; i < 3; i++) q1.push_back(mk(1'b0, 32'(64 + 4 * i), 32'h0, CTRL_W, 1'b0));
    hist.delete();
    for (int i = 0; i < 18; i++) cycle();
    for (int i = 0; i < 18; i++) chk($sformatf("starve_h%0d", i), 32'(hist[i]), (i == 8 || i == 17) ? 32'd2 : 32'd1);
    drain();

    // Burst lock bounded at MAX_LOCK beats.
    for (int i = 0; i < 6; i++) q1.push_back(mk(1'b1, 32'h20, 32'h1122_3344, CTRL_W, 1'b1));
    hist.delete();
    cycle();
    q0.push_back(mk(1'b0, 32'h20, 32'h0, CTRL_W, 1'b0));
    for (int i = 0; i < 6; i++) cycle();
    for (int i = 0; i < 7; i++) chk($sformatf("lock_h%0d", i), 32'(hist[i]), (i == 4) ? 32'd1 : 32'd2);
    chk("lock_cpu_rdata0", rdata0, 32'h1122_3344);
    drain();

    // Reset while locked with a DMA load granted.
    q1.push_back(mk(1'b0, 32'h10, 32'h0, CTRL_W, 1'b1));
    q1.push_back(mk(1'b0, 32'h14, 32'h0, CTRL_W, 1'b1));
    hist.delete();
    cycle();
    cycle();
    chk("rstlk_gnt_locked", 32'(hist[1]), 32'd2);
    do_reset();
    cycle();
    chk("rstlk_rvalid1", rvalid1, 1'b0);
    chk("rstlk_gnt1", gnt1, 1'b0);
    rst = 1'b0;
    q0.push_back(mk(1'b0, 32'h10, 32'h0, CTRL_W, 1'b0));
    q1.push_back(mk(1'b0, 32'h14, 32'h0, CTRL_W, 1'b1));
    hist.delete();
    cycle();
    cycle();
    cycle();
    chk("rstlk_h0", 32'(hist[0]), 32'd1);
    chk("rstlk_h1", 32'(hist[1]), 32'd2);
    drain();

    // Random traffic from both ports.
    for (int c = 0; c < 400; c++) begin
      if (q0.size() < 2 && $urandom_range(0, 3) != 0) q0.push_back(rand_tx(1'b0));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_tx(1'b1));
      cycle();
      chk("one_grant", 32'(gnt0 & gnt1), 32'd0);
    end
    drain();
    chk("sb_leftover", 32'(eq0.size() + eq1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
